// File: rtl/lsu_pkg.sv
// Shared load/store types and request decode helpers.
// Used by the FSM and the data steering so both agree on op semantics.
package lsu_pkg;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    typedef struct packed {
        mem_op_t           op;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } lsu_req_t;

    function automatic logic is_load(input mem_op_t op);
        return op inside {LW, LH, LHU, LB, LBU};
    endfunction

    function automatic logic is_subword_store(input mem_op_t op);
        return op inside {SH, SB};
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] lo);
        logic bad;
        case (op)
            LW, SW:      bad = (lo != 2'b00);
            LH, LHU, SH: bad = lo[0];
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction
endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit.
// master = memory stage of the core, slave = lsu_ctrl.
interface lsu_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    mem_op_t           req_op;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: load extension and sub-word store merge; purely combinational.
// No state and no flow control; the controller decides when outputs are used.
module lsu_align
    import lsu_pkg::*;
(
    input  mem_op_t           op,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] rd_word,
    input  logic [HALF_W-1:0] wdata,
    output logic [WORD_W-1:0] load_ext,
    output logic [WORD_W-1:0] merged_word
);
    logic [BYTE_W-1:0] rd_byte;
    logic [HALF_W-1:0] rd_half;

    // Little-endian lanes: byte k at bit 8k, halfword h at bit 16h.
    assign rd_byte = rd_word[{addr_lo, 3'b000} +: BYTE_W];
    assign rd_half = rd_word[{addr_lo[1], 4'b0000} +: HALF_W];

    always_comb begin
        load_ext = rd_word;
        case (op)
            LB:      load_ext = {{(WORD_W-BYTE_W){rd_byte[BYTE_W-1]}}, rd_byte};
            LBU:     load_ext = {{(WORD_W-BYTE_W){1'b0}}, rd_byte};
            LH:      load_ext = {{(WORD_W-HALF_W){rd_half[HALF_W-1]}}, rd_half};
            LHU:     load_ext = {{(WORD_W-HALF_W){1'b0}}, rd_half};
            default: load_ext = rd_word;
        endcase
    end

    always_comb begin
        merged_word = rd_word;
        if (op == SB) begin
            merged_word[{addr_lo, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
        end else if (op == SH) begin
            merged_word[{addr_lo[1], 4'b0000} +: HALF_W] = wdata;
        end
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator to a single-port word memory; 3 cycles per load/SW, 4 per SB/SH (RMW), 2 per error.
// req_ready only in IDLE; requests presented while busy are ignored, not queued.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_if.slave              core,
    output logic [WORD_W-1:0] mem_a,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wd,
    input  logic [WORD_W-1:0] mem_rd
);
    lsu_state_t        state, state_nxt;
    lsu_req_t          req_q;
    logic [WORD_W-1:0] merged_q;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;
    logic              req_bad;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] load_ext;
    logic [WORD_W-1:0] merged_word;

    // Bad requests are caught at acceptance so they never drive the memory.
    assign req_bad = is_misaligned(core.req_op, core.req_addr[1:0]) ||
                     ({2'b00, core.req_addr[WORD_W-1:2]} >= WORD_W'(DEPTH));

    lsu_align u_align (
        .op          (req_q.op),
        .addr_lo     (req_q.addr[1:0]),
        .rd_word     (mem_rd),
        .wdata       (req_q.wdata[HALF_W-1:0]),
        .load_ext    (load_ext),
        .merged_word (merged_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (core.req_valid) state_nxt = req_bad ? RESP : ACCESS;
            ACCESS:  state_nxt = is_subword_store(req_q.op) ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_a      = '0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            ACCESS: begin
                mem_a = {req_q.addr[WORD_W-1:2], 2'b00};
                if (req_q.op == SW) begin
                    mem_we = 1'b1;
                    mem_wd = req_q.wdata;
                end
            end
            WRITE: begin
                mem_a  = {req_q.addr[WORD_W-1:2], 2'b00};
                mem_we = 1'b1;
                mem_wd = merged_q;
            end
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Response fields change only on the transition into RESP, so they hold between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        req_q.op    <= core.req_op;
                        req_q.addr  <= core.req_addr;
                        req_q.wdata <= core.req_wdata;
                        if (req_bad) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (is_load(req_q.op)) begin
                        rdata_q <= load_ext;
                        err_q   <= 1'b0;
                    end else if (req_q.op == SW) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end else begin
                        merged_q <= merged_word;
                    end
                end
                WRITE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign core.req_ready  = req_ready;
    assign core.resp_valid = resp_valid;
    assign core.resp_rdata = rdata_q;
    assign core.resp_err   = err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, busy/back-to-back and mid-RMW reset sequences,
// then random requests checked against a byte-array reference model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    typedef struct {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        clr_mem;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [31:0] tb_mem  [DEPTH];
    logic [7:0]  ref_mem [DEPTH*4];
    int          n_chk;
    int          n_fail;
    vec_t        vt[$];

    logic [31:0] g_rd, g_hold;
    logic        g_err, g_rdy;
    int          g_lat, g_we, g_wecyc;

    lsu_if core_bus();

    lsu_ctrl #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .core   (core_bus),
        .mem_a  (mem_a),
        .mem_we (mem_we),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = tb_mem[mem_a[AW+1:2]];
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= '0;
        end else if (mem_we) begin
            tb_mem[mem_a[AW+1:2]] <= mem_wd;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_ready"},  32'(core_bus.req_ready), 32'd1);
        chk({tag, " resp_valid"}, 32'(core_bus.resp_valid), 32'd0);
        chk({tag, " resp_rdata"}, core_bus.resp_rdata, 32'd0);
        chk({tag, " resp_err"},   32'(core_bus.resp_err), 32'd0);
        chk({tag, " mem_we"},     32'(mem_we), 32'd0);
        chk({tag, " mem_a"},      mem_a, 32'd0);
        chk({tag, " mem_wd"},     mem_wd, 32'd0);
    endtask

    // Reference: memory as a flat byte array, accesses described by size and byte offset.
    task automatic ref_exec(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic err, output int lat, output int we);
        int unsigned size;
        int unsigned a;
        logic [31:0] v;
        a    = addr;
        size = (op == LW || op == SW) ? 4 : (op inside {LH, LHU, SH}) ? 2 : 1;
        err  = ((a % size) != 0) || ((a / 4) >= DEPTH);
        rd   = '0;
        we   = 0;
        lat  = 1;
        if (!err) begin
            if (op inside {SW, SH, SB}) begin
                for (int unsigned i = 0; i < size; i++) ref_mem[a+i] = 8'(wdata >> (8*i));
                we  = 1;
                lat = (size == 4) ? 2 : 3;
            end else begin
                v = '0;
                for (int unsigned i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
                if ((op == LB || op == LH) && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd  = v;
                lat = 2;
            end
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the edge that ends RESP.
    task automatic do_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wdata);
        core_bus.req_valid = 1'b1;
        core_bus.req_op    = op;
        core_bus.req_addr  = addr;
        core_bus.req_wdata = wdata;
        @(posedge clk); #1;
        core_bus.req_valid = 1'b0;
        g_lat = 0; g_we = 0; g_wecyc = 0; g_rd = '0; g_err = 1'b0; g_rdy = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            if (mem_we) begin
                g_we++;
                g_wecyc = c;
            end
            if (core_bus.resp_valid) begin
                g_lat = c;
                g_rd  = core_bus.resp_rdata;
                g_err = core_bus.resp_err;
                g_rdy = core_bus.req_ready;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        g_hold = core_bus.resp_rdata;
    endtask

    task automatic add(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input logic err, input int lat, input int we);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wd; v.rdata = rd; v.err = err; v.lat = lat; v.we = we;
        vt.push_back(v);
    endtask

    logic [31:0] e_rd, addr, wd;
    logic        e_err;
    int          e_lat, e_we, sel, resp_n, we_seen;
    logic [31:0] b_dat [3];
    int          b_cyc [3];
    mem_op_t     op;

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0; clr_mem = 1'b1;
        core_bus.req_valid = 1'b0; core_bus.req_op = LW;
        core_bus.req_addr = '0; core_bus.req_wdata = '0;
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = '0;
        #1;
        chk_reset("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; clr_mem = 1'b0;

        add(SW,  32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1);
        add(LW,  32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
        add(SW,  32'h10,  32'h80FF7F01, 32'h0,        1'b0, 2, 1);
        add(LB,  32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0);
        add(LBU, 32'h13,  32'h0,        32'h00000080, 1'b0, 2, 0);
        add(LH,  32'h12,  32'h0,        32'hFFFF80FF, 1'b0, 2, 0);
        add(LHU, 32'h10,  32'h0,        32'h00007F01, 1'b0, 2, 0);
        add(SW,  32'h20,  32'h11223344, 32'h0,        1'b0, 2, 1);
        add(SB,  32'h21,  32'h000000AB, 32'h0,        1'b0, 3, 1);
        add(LW,  32'h20,  32'h0,        32'h1122AB44, 1'b0, 2, 0);
        add(SH,  32'h22,  32'hFFFFCAFE, 32'h0,        1'b0, 3, 1);
        add(LW,  32'h20,  32'h0,        32'hCAFEAB44, 1'b0, 2, 0);
        add(LW,  32'h02,  32'h0,        32'h0,        1'b1, 1, 0);
        add(SH,  32'h05,  32'h1111,     32'h0,        1'b1, 1, 0);
        add(SW,  32'h400, 32'h12345678, 32'h0,        1'b1, 1, 0);
        add(LH,  32'h11,  32'h0,        32'h0,        1'b1, 1, 0);
        add(SB,  32'h400, 32'h55,       32'h0,        1'b1, 1, 0);
        add(SW,  32'h3FC, 32'h80000000, 32'h0,        1'b0, 2, 1);
        add(LB,  32'h3FF, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0);
        add(LW,  32'h10,  32'h0,        32'h80FF7F01, 1'b0, 2, 0);
        add(LW,  32'h20,  32'h0,        32'hCAFEAB44, 1'b0, 2, 0);

        foreach (vt[i]) begin
            ref_exec(vt[i].op, vt[i].addr, vt[i].wdata, e_rd, e_err, e_lat, e_we);
            do_req(vt[i].op, vt[i].addr, vt[i].wdata);
            chk($sformatf("vec%0d rdata", i), g_rd, vt[i].rdata);
            chk($sformatf("vec%0d err", i), 32'(g_err), 32'(vt[i].err));
            chk($sformatf("vec%0d resp cycle", i), 32'(g_lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d we pulses", i), 32'(g_we), 32'(vt[i].we));
            if (vt[i].we != 0) chk($sformatf("vec%0d we cycle", i), 32'(g_wecyc), 32'(vt[i].lat - 1));
            chk($sformatf("vec%0d ready in resp", i), 32'(g_rdy), 32'd0);
            chk($sformatf("vec%0d rdata hold", i), g_hold, vt[i].rdata);
            chk($sformatf("vec%0d ready after", i), 32'(core_bus.req_ready), 32'd1);
        end

        // req_valid held high; only edges 0, 3 and 6 find the unit idle.
        resp_n = 0; we_seen = 0;
        for (int k = 0; k < 9; k++) begin
            core_bus.req_valid = 1'b1;
            core_bus.req_wdata = 32'h55555555;
            case (k)
                0: begin core_bus.req_op = LW; core_bus.req_addr = 32'h10;  end
                3: begin core_bus.req_op = LW; core_bus.req_addr = 32'h20;  end
                6: begin core_bus.req_op = LW; core_bus.req_addr = 32'h3FC; end
                default: begin
                    core_bus.req_op   = mem_op_t'(3'(5 + (k % 3)));
                    core_bus.req_addr = 32'h20 + 32'(k % 2);
                end
            endcase
            @(posedge clk); #1;
            if (mem_we) we_seen++;
            if (core_bus.resp_valid) begin
                if (resp_n < 3) begin
                    b_dat[resp_n] = core_bus.resp_rdata;
                    b_cyc[resp_n] = k + 1;
                end
                resp_n++;
            end
        end
        core_bus.req_valid = 1'b0;
        chk("b2b responses", 32'(resp_n), 32'd3);
        chk("b2b we pulses", 32'(we_seen), 32'd0);
        chk("b2b resp0 cycle", 32'(b_cyc[0]), 32'd2);
        chk("b2b resp1 cycle", 32'(b_cyc[1]), 32'd5);
        chk("b2b resp2 cycle", 32'(b_cyc[2]), 32'd8);
        chk("b2b resp0 data", b_dat[0], 32'h80FF7F01);
        chk("b2b resp1 data", b_dat[1], 32'hCAFEAB44);
        chk("b2b resp2 data", b_dat[2], 32'h80000000);
        chk("b2b ready after", 32'(core_bus.req_ready), 32'd1);

        // Reset lands while the SB is in its read phase.
        core_bus.req_valid = 1'b1; core_bus.req_op = SB;
        core_bus.req_addr = 32'h21; core_bus.req_wdata = 32'h77;
        @(posedge clk); #1;
        core_bus.req_valid = 1'b0;
        chk("rmw access mem_a", mem_a, 32'h20);
        chk("rmw access mem_we", 32'(mem_we), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset("mid-rmw reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid-rmw no resp", 32'(core_bus.resp_valid), 32'd0);
        chk("mid-rmw word kept", tb_mem[8], 32'hCAFEAB44);
        rst_n = 1'b1;
        do_req(LW, 32'h20, 32'h0);
        chk("post-reset LW rdata", g_rd, 32'hCAFEAB44);
        chk("post-reset LW cycle", 32'(g_lat), 32'd2);

        for (int n = 0; n < 150; n++) begin
            op  = mem_op_t'(3'($urandom_range(0, 7)));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      addr = 32'((DEPTH + int'($urandom_range(0, 3))) * 4) + 32'($urandom_range(0, 3));
            else if (sel == 8) addr = 32'((DEPTH - 1) * 4) + 32'($urandom_range(0, 3));
            else if (sel == 9) addr = $urandom();
            else               addr = 32'(int'($urandom_range(0, 7)) * 4) + 32'($urandom_range(0, 3));
            wd = $urandom();
            ref_exec(op, addr, wd, e_rd, e_err, e_lat, e_we);
            do_req(op, addr, wd);
            chk($sformatf("rnd%0d %s @%h rdata", n, op.name(), addr), g_rd, e_rd);
            chk($sformatf("rnd%0d %s @%h err", n, op.name(), addr), 32'(g_err), 32'(e_err));
            chk($sformatf("rnd%0d %s @%h cycle", n, op.name(), addr), 32'(g_lat), 32'(e_lat));
            chk($sformatf("rnd%0d %s @%h we", n, op.name(), addr), 32'(g_we), 32'(e_we));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        for (int w = 0; w < DEPTH; w++) chk($sformatf("mem word %0d", w), tb_mem[w], ref_word(w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
